// File: rtl/serial_subtractor_pkg.sv
// -----------------------------------------------------------------------------
// serial_subtractor_pkg
//   Definitions shared by the bit-serial subtractor:
//     - state_e : FSM encoding (S_IDLE=2'd0, S_SHIFT=2'd1, S_DONE=2'd2)
//     - clog2   : counter-width helper (never returns less than 1 bit)
// -----------------------------------------------------------------------------
package serial_subtractor_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  // Ceiling log2, clamped to at least one bit so a counter is always legal.
  function automatic int clog2(input int value);
    int width_v;
    int span_v;
    width_v = 32'sd0;
    span_v  = 32'sd1;
    while (span_v < value) begin
      span_v  = span_v * 32'sd2;
      width_v = width_v + 32'sd1;
    end
    if (width_v < 32'sd1) begin
      width_v = 32'sd1;
    end
    return width_v;
  endfunction

endpackage

// File: rtl/full_subtractor.sv
// -----------------------------------------------------------------------------
// full_subtractor
//   Single-bit combinational full subtractor: x - y - bin.
//   Ports:
//     d    out 1  difference bit      = x ^ y ^ bin
//     bout out 1  borrow to next bit  = (~x & y) | (~(x ^ y) & bin)
//     x    in  1  minuend bit
//     y    in  1  subtrahend bit
//     bin  in  1  borrow from the previous (less significant) bit
// -----------------------------------------------------------------------------
module full_subtractor (
  output logic d,
  output logic bout,
  input  logic x,
  input  logic y,
  input  logic bin
);

  logic xy_diff_s;

  // Difference and borrow of one bit position.
  always_comb begin
    xy_diff_s = x ^ y;
    d         = xy_diff_s ^ bin;
    bout      = (~x & y) | (~xy_diff_s & bin);
  end

endmodule

// File: rtl/serial_subtractor.sv
// -----------------------------------------------------------------------------
// serial_subtractor
//   Bit-serial subtractor computing diff = a - b, LSB first, one bit per clock,
//   through a single full_subtractor cell and a registered borrow.
//   start (IDLE only) loads a/b; WIDTH SHIFT cycles later the result lands in
//   diff/borrow_out together with a one-cycle done pulse. Result holds until
//   the next accepted start. Start-to-done latency is WIDTH+1 cycles, one
//   operation every WIDTH+2 cycles.
//
//   Optional feature macro: SERIAL_SUB_OVF_EN adds the signed 'overflow' port.
//
//   Ports:
//     clk         in   1      rising-edge clock
//     rst         in   1      synchronous active-high reset
//     start       in   1      load a/b and begin (ignored unless IDLE)
//     a           in   WIDTH  minuend
//     b           in   WIDTH  subtrahend
//     busy        out  1      high while shifting
//     done        out  1      one-cycle pulse, result valid from this cycle
//     diff        out  WIDTH  a - b modulo 2^WIDTH
//     borrow_out  out  1      final borrow (a < b unsigned)
//     overflow    out  1      signed overflow (SERIAL_SUB_OVF_EN only)
// -----------------------------------------------------------------------------
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             overflow
`endif
);

  localparam int              CNT_W    = clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_e           state_r;
  logic [WIDTH-1:0] a_sh_r;
  logic [WIDTH-1:0] b_sh_r;
  logic [WIDTH-1:0] result_r;
  logic             bor_r;
  logic [CNT_W-1:0] cnt_r;
`ifdef SERIAL_SUB_OVF_EN
  logic             a_msb_r;
  logic             b_msb_r;
`endif

  logic             d_s;
  logic             bout_s;
  logic [WIDTH-1:0] next_result_s;

  // The one bit-cell, fed by the shift-register LSBs and the borrow flop.
  full_subtractor u_cell (
    .d    (d_s),
    .bout (bout_s),
    .x    (a_sh_r[0]),
    .y    (b_sh_r[0]),
    .bin  (bor_r)
  );

  // Result register shifted right with the new difference bit entering at the
  // MSB; after WIDTH shifts the first (LSB) bit has reached position 0.
  always_comb begin
    next_result_s = (result_r >> 1) | {d_s, {(WIDTH-1){1'b0}}};
  end

  // Control FSM, datapath registers and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= S_IDLE;
      a_sh_r     <= {WIDTH{1'b0}};
      b_sh_r     <= {WIDTH{1'b0}};
      result_r   <= {WIDTH{1'b0}};
      bor_r      <= 1'b0;
      cnt_r      <= {CNT_W{1'b0}};
      busy       <= 1'b0;
      done       <= 1'b0;
      diff       <= {WIDTH{1'b0}};
      borrow_out <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      a_msb_r    <= 1'b0;
      b_msb_r    <= 1'b0;
      overflow   <= 1'b0;
`endif
    end else begin
      case (state_r)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_sh_r   <= a;
            b_sh_r   <= b;
            result_r <= {WIDTH{1'b0}};
            bor_r    <= 1'b0;
            cnt_r    <= {CNT_W{1'b0}};
            busy     <= 1'b1;
            state_r  <= S_SHIFT;
`ifdef SERIAL_SUB_OVF_EN
            a_msb_r  <= a[WIDTH-1];
            b_msb_r  <= b[WIDTH-1];
`endif
          end else begin
            busy <= 1'b0;
          end
        end

        S_SHIFT: begin
          a_sh_r   <= a_sh_r >> 1;
          b_sh_r   <= b_sh_r >> 1;
          result_r <= next_result_s;
          bor_r    <= bout_s;
          cnt_r    <= cnt_r + CNT_ONE;
          if (cnt_r == CNT_LAST) begin
            // Last bit: publish the finished word and raise done for DONE.
            busy       <= 1'b0;
            done       <= 1'b1;
            diff       <= next_result_s;
            borrow_out <= bout_s;
            state_r    <= S_DONE;
`ifdef SERIAL_SUB_OVF_EN
            // Signed overflow: operand signs differ and the result sign
            // disagrees with the minuend sign (d_s is the result MSB).
            overflow   <= (a_msb_r != b_msb_r) & (d_s != a_msb_r);
`endif
          end else begin
            busy <= 1'b1;
          end
        end

        S_DONE: begin
          // Start is not honoured here; IDLE follows unconditionally.
          done    <= 1'b0;
          busy    <= 1'b0;
          state_r <= S_IDLE;
        end

        default: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          state_r <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// -----------------------------------------------------------------------------
// tb_serial_subtractor
//   Directed, self-checking bench for serial_subtractor (WIDTH=8).
//   Inputs are driven on the falling edge, outputs sampled on the falling edge.
//   Overflow checks are compiled in when SERIAL_SUB_OVF_EN is defined.
// -----------------------------------------------------------------------------
module tb_serial_subtractor;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic       busy;
  logic       done;
  logic [7:0] diff;
  logic       borrow_out;
`ifdef SERIAL_SUB_OVF_EN
  logic       overflow;
`endif

  int checks;
  int errors;
  int done_cnt;

  serial_subtractor #(.WIDTH(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .a          (a),
    .b          (b),
    .busy       (busy),
    .done       (done),
    .diff       (diff),
    .borrow_out (borrow_out)
`ifdef SERIAL_SUB_OVF_EN
    ,
    .overflow   (overflow)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count done pulses independently of the stimulus thread.
  always @(posedge clk) begin
    if (done === 1'b1) done_cnt <= done_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Start one operation in the next cycle, check hold/busy, wait (bounded) for
  // done and check latency and result. Returns in the done cycle.
  task automatic run_op(input logic [7:0] op_a, input logic [7:0] op_b,
                        input logic [7:0] exp_diff, input logic exp_bor,
                        input logic [7:0] prev_diff, input string tag);
    int k;
    @(negedge clk);
    a = op_a; b = op_b; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k = 1;
    check({tag, "_busy"}, 32'(busy), 32'd1);
    check({tag, "_hold"}, 32'(diff), 32'(prev_diff));
    while (done !== 1'b1 && k < 20) begin
      @(negedge clk);
      k++;
    end
    check({tag, "_latency"}, 32'(k), 32'd9);
    check({tag, "_diff"}, 32'(diff), 32'(exp_diff));
    check({tag, "_borrow"}, 32'(borrow_out), 32'(exp_bor));
    check({tag, "_busy_done"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int k;
    int base;
    checks = 0; errors = 0; done_cnt = 0;
    rst = 1'b1; start = 1'b0; a = 8'd0; b = 8'd0;

    // Reset held for two cycles.
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_diff", 32'(diff), 32'd0);
    check("rst_borrow", 32'(borrow_out), 32'd0);

    // Basic, wrap-around and signed-overflow vectors.
    run_op(8'd9, 8'd5, 8'd4, 1'b0, 8'd0, "basic");
`ifdef SERIAL_SUB_OVF_EN
    check("basic_ovf", 32'(overflow), 32'd0);
`endif
    run_op(8'd0, 8'd1, 8'hFF, 1'b1, 8'd4, "wrap");
`ifdef SERIAL_SUB_OVF_EN
    check("wrap_ovf", 32'(overflow), 32'd0);
`endif
    run_op(8'h80, 8'h01, 8'h7F, 1'b0, 8'hFF, "sgn");
`ifdef SERIAL_SUB_OVF_EN
    check("sgn_ovf", 32'(overflow), 32'd1);
`endif

    // Start pulsed mid-operation must be ignored.
    @(negedge clk);
    a = 8'd200; b = 8'd100; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k = 1;
    base = done_cnt;
    while (done !== 1'b1 && k < 20) begin
      if (k == 3) begin
        a = 8'd1; b = 8'd1; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      k++;
    end
    start = 1'b0;
    check("ign_latency", 32'(k), 32'd9);
    check("ign_diff", 32'(diff), 32'd100);
    check("ign_borrow", 32'(borrow_out), 32'd0);
    repeat (12) @(negedge clk);
    check("ign_done_count", 32'(done_cnt - base), 32'd1);
    check("ign_diff_hold", 32'(diff), 32'd100);

    // Reset in the middle of an operation aborts it.
    @(negedge clk);
    a = 8'd50; b = 8'd20; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_diff", 32'(diff), 32'd0);
    check("abort_borrow", 32'(borrow_out), 32'd0);
    base = done_cnt;
    repeat (12) @(negedge clk);
    check("abort_no_done", 32'(done_cnt - base), 32'd0);
    run_op(8'd50, 8'd20, 8'd30, 1'b0, 8'd0, "restart");

    // Back-to-back: each run_op starts in the cycle right after done.
    run_op(8'd3, 8'd250, 8'd9, 1'b1, 8'd30, "b2b");
`ifdef SERIAL_SUB_OVF_EN
    check("b2b_ovf", 32'(overflow), 32'd0);
`endif
    run_op(8'hA5, 8'hA5, 8'd0, 1'b0, 8'd9, "equal");

    // rst and start in the same cycle: reset wins.
    @(negedge clk);
    rst = 1'b1; start = 1'b1; a = 8'd9; b = 8'd5;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    check("rst_start_busy", 32'(busy), 32'd0);
    base = done_cnt;
    repeat (12) @(negedge clk);
    check("rst_start_no_done", 32'(done_cnt - base), 32'd0);
    check("rst_start_diff", 32'(diff), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
